fact_seq: RTL and testbench

Multi-cycle factorial sequencer for the calculator datapath. It accepts an operand and a start request from the control unit, then computes n! by iterated shift-add multiplication. When finished it returns the result, overflow and zero flags, and a one-cycle completion pulse. The completion pulse drives the control unit's FACT_END input.

---
 rtl/gpp_fact_pkg.sv | 11 +
 rtl/fact_mul_step.sv | 29 ++
 rtl/fact_seq.sv | 95 +++++++++
 tb/tb_fact_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gpp_fact_pkg.sv
// gpp_fact_pkg: shared state encoding and default width for the factorial sequencer
package gpp_fact_pkg;
    localparam int FACT_WIDTH = 16;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        MUL  = 3'd2,
        STEP = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/fact_mul_step.sv
// fact_mul_step: serial shift-add multiplier, one multiplier bit per cycle, product valid WIDTH cycles after load
module fact_mul_step
    import gpp_fact_pkg::*;
#(
    parameter int WIDTH = FACT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod
);
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   sum;
    // multiplier sits in the low half and is shifted out as the product grows in from the top
    assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand <= '0;
            prod  <= '0;
        end else if (load) begin
            mcand <= a;
            prod  <= {{WIDTH{1'b0}}, b};
        end else begin
            prod  <= {sum, prod[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/fact_seq.sv
// fact_seq: multi-cycle n! sequencer using a serial multiplier; define FACT_SAT_EN to saturate
// and stop early on the first overflowing multiply instead of wrapping mod 2^WIDTH
module fact_seq
    import gpp_fact_pkg::*;
#(
    parameter int WIDTH = FACT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero
);
    localparam int IW = $clog2(WIDTH);
    state_t             state, state_nxt;
    logic [WIDTH-1:0]   cnt, cnt_nxt, acc, acc_nxt;
    logic               ovf_int, ovf_int_nxt, load, hi_ovf;
    logic [IW-1:0]      it;
    logic [2*WIDTH-1:0] prod;
    assign hi_ovf = |prod[2*WIDTH-1:WIDTH];
    assign busy   = state != IDLE;
    assign done   = state == DONE;
    // the multiplier loads with the values being registered this edge, so it sees acc/cnt as of MUL entry
    assign load   = (state_nxt == MUL) && (state != MUL);
    fact_mul_step #(.WIDTH(WIDTH)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .a    (acc_nxt),
        .b    (cnt_nxt),
        .prod (prod)
    );
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        ovf_int_nxt = ovf_int;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = INIT;
                    cnt_nxt   = operand;
                end
            end
            INIT: begin
                acc_nxt     = WIDTH'(1);
                ovf_int_nxt = 1'b0;
                state_nxt   = (cnt <= WIDTH'(1)) ? DONE : MUL;
            end
            MUL:  state_nxt = (it == IW'(WIDTH-1)) ? STEP : MUL;
            STEP: begin
                acc_nxt     = prod[WIDTH-1:0];
                ovf_int_nxt = ovf_int | hi_ovf;
                cnt_nxt     = cnt - 1'b1;
                state_nxt   = (cnt_nxt == WIDTH'(1)) ? DONE : MUL;
`ifdef FACT_SAT_EN
                if (hi_ovf) begin
                    acc_nxt   = '1;
                    state_nxt = DONE;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            ovf_int <= 1'b0;
            it      <= '0;
            result  <= '0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            acc     <= acc_nxt;
            ovf_int <= ovf_int_nxt;
            it      <= (state == MUL) ? it + 1'b1 : '0;
            // outputs land on the edge entering DONE so they are valid alongside the done pulse
            if (state_nxt == DONE) begin
                result <= acc_nxt;
                ovf    <= ovf_int_nxt;
                zero   <= acc_nxt == '0;
            end
        end
    end
endmodule

// File: tb/tb_fact_seq.sv
// tb_fact_seq: directed self-checking bench for fact_seq (16-bit main instance, 8-bit instance for the all-ones run)
module tb_fact_seq;
    logic        clk = 1'b0;
    logic        rst, start, start8;
    logic [15:0] operand;
    logic [7:0]  operand8;
    logic        busy, done, ovf, zero, busy8, done8, ovf8, zero8;
    logic [15:0] result;
    logic [7:0]  result8;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fact_seq #(.WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .operand(operand),
        .busy(busy), .done(done), .result(result), .ovf(ovf), .zero(zero)
    );

    fact_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .operand(operand8),
        .busy(busy8), .done(done8), .result(result8), .ovf(ovf8), .zero(zero8)
    );

    task automatic launch(input logic [15:0] op);
        @(negedge clk);
        operand = op;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
        end while (!done && cyc < limit);
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; start8 = 1'b0; operand = 16'd5; operand8 = '0;
        #3;
        checks++;
        if ({busy, done, result, ovf, zero} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b result=%h ovf=%b zero=%b want all 0", busy, done, result, ovf, zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fact5;
        int c, b;
        launch(16'd5);
        wait_done(300, c, b);
        checks++; if (c !== 70) begin errors++; $display("FAIL fact5_latency got %0d want 70", c); end
        checks++; if (result !== 16'h0078) begin errors++; $display("FAIL fact5_result got %h want 0078", result); end
        checks++; if ({ovf, zero} !== 2'b00) begin errors++; $display("FAIL fact5_flags got ovf=%b zero=%b want 0 0", ovf, zero); end
    endtask

    task automatic test_small;
        int c, b;
        for (int n = 0; n < 2; n++) begin
            launch(16'(n));
            wait_done(50, c, b);
            checks++; if (c !== 2) begin errors++; $display("FAIL small%0d_latency got %0d want 2", n, c); end
            checks++; if (b !== 2) begin errors++; $display("FAIL small%0d_busy_cycles got %0d want 2", n, b); end
            checks++; if (result !== 16'd1) begin errors++; $display("FAIL small%0d_result got %h want 0001", n, result); end
            checks++; if ({ovf, zero} !== 2'b00) begin errors++; $display("FAIL small%0d_flags got ovf=%b zero=%b want 0 0", n, ovf, zero); end
        end
    endtask

    task automatic test_fact8_9;
        int c, b;
        launch(16'd8);
        wait_done(300, c, b);
        checks++; if (c !== 121) begin errors++; $display("FAIL fact8_latency got %0d want 121", c); end
        checks++; if (result !== 16'h9D80) begin errors++; $display("FAIL fact8_result got %h want 9d80", result); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fact8_ovf got %b want 0", ovf); end
        launch(16'd9);
        wait_done(300, c, b);
`ifdef FACT_SAT_EN
        checks++; if (c !== 121) begin errors++; $display("FAIL fact9_latency got %0d want 121", c); end
        checks++; if (result !== 16'hFFFF) begin errors++; $display("FAIL fact9_result got %h want ffff", result); end
`else
        checks++; if (c !== 138) begin errors++; $display("FAIL fact9_latency got %0d want 138", c); end
        checks++; if (result !== 16'h8980) begin errors++; $display("FAIL fact9_result got %h want 8980", result); end
`endif
        checks++; if ({ovf, zero} !== 2'b10) begin errors++; $display("FAIL fact9_flags got ovf=%b zero=%b want 1 0", ovf, zero); end
    endtask

    task automatic test_ignore_start;
        int c, b;
        launch(16'd6);
        repeat (30) @(negedge clk);
        operand = 16'd3;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(300, c, b);
        checks++; if (c + 31 !== 87) begin errors++; $display("FAIL ignore_latency got %0d want 87", c + 31); end
        checks++; if (result !== 16'd720) begin errors++; $display("FAIL ignore_result got %0d want 720", result); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int c, b;
        launch(16'd1);
        wait_done(50, c, b);
        operand = 16'd2;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle_start got busy=%b want 0", busy); end
        launch(16'd3);
        wait_done(300, c, b);
        checks++; if (c !== 36) begin errors++; $display("FAIL b2b_latency got %0d want 36", c); end
        checks++; if (result !== 16'd6) begin errors++; $display("FAIL b2b_result got %0d want 6", result); end
    endtask

    task automatic test_async_reset;
        int c, b;
        launch(16'd5);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, ovf, zero} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b result=%h ovf=%b zero=%b want all 0", busy, done, result, ovf, zero);
        end
        @(negedge clk);
        rst = 1'b1;
        launch(16'd4);
        wait_done(300, c, b);
        checks++; if (c !== 53) begin errors++; $display("FAIL after_reset_latency got %0d want 53", c); end
        checks++; if (result !== 16'd24) begin errors++; $display("FAIL after_reset_result got %0d want 24", result); end
    endtask

    task automatic test_wrap_all_ones;
        int c = 0;
        int dones = 0;
        @(negedge clk);
        operand8 = 8'hFF;
        start8   = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        do begin
            @(negedge clk);
            c++;
            if (done8) dones++;
        end while (!done8 && c < 3000);
`ifdef FACT_SAT_EN
        checks++; if (c !== 11) begin errors++; $display("FAIL ones_latency got %0d want 11", c); end
        checks++; if (result8 !== 8'hFF) begin errors++; $display("FAIL ones_result got %h want ff", result8); end
        checks++; if ({ovf8, zero8} !== 2'b10) begin errors++; $display("FAIL ones_flags got ovf=%b zero=%b want 1 0", ovf8, zero8); end
`else
        checks++; if (c !== 2288) begin errors++; $display("FAIL ones_latency got %0d want 2288", c); end
        checks++; if (result8 !== 8'h00) begin errors++; $display("FAIL ones_result got %h want 00", result8); end
        checks++; if ({ovf8, zero8} !== 2'b11) begin errors++; $display("FAIL ones_flags got ovf=%b zero=%b want 1 1", ovf8, zero8); end
`endif
        repeat (20) begin
            @(negedge clk);
            if (done8) dones++;
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL ones_done_count got %0d want 1", dones); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fact5();
        test_small();
        test_fact8_9();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_wrap_all_ones();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
